// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, S-box table, round-constant function and FSM states
// Purpose: common definitions for the AES key-schedule blocks.
//   KEY_W / NR : AES-128 key width and round count.
//   state_t    : scheduler FSM states (ST_IDLE, ST_RUN).
//   SBOX       : 256-entry S-box packed into 2048 bits, entry 0 in the MSBs.
//   sbox(x)    : single S-box byte lookup.
//   rcon(i)    : round constant byte for round i (1..10), 0 elsewhere.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int NR    = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Shift the wanted entry up to the top byte; avoids a computed part-select base.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX << {x, 3'b000};
    return t[2047:2040];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - combinational 32-bit AES SubWord
// Purpose: applies the AES S-box to each byte of a 32-bit word.
// Ports:
//   w  in  32  input word
//   s  out 32  substituted word (byte order preserved)
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] s
);

  assign s = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// rtl/aes_inv_key_scheduler.sv - iterative AES-128 inverse key expansion, round 10 down to 0
// Purpose: from the round-10 key, streams decrypt round keys 10..0, one per
//   rk_valid & rk_ready handshake, by running the forward expansion backwards.
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   start      in   1    begin a schedule (sampled only in IDLE)
//   last_key   in   128  round-10 key, captured when start is accepted
//   rk_ready   in   1    consumer accepts round_key
//   round_key  out  128  current round key, w0 in [127:96]
//   round_idx  out  4    round number of round_key
//   rk_valid   out  1    round_key/round_idx valid
//   busy       out  1    schedule in progress
//   done       out  1    one-cycle pulse after the round-0 key is accepted
module aes_inv_key_scheduler
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] last_key,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             rk_valid,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [KEY_W-1:0] key_n;
  logic [3:0]       idx_n;
  logic             done_n;

  // prev(): recover the previous round's words; only w0 needs the S-box path.
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sw;

  assign {w0, w1, w2, w3} = round_key;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  aes_sub_word u_sub_word (
    .w ({p3[23:0], p3[31:24]}),
    .s (sw)
  );

  assign p0 = w0 ^ sw ^ {rcon(round_idx), 24'h000000};

  // In RUN a key is always presented, so valid and busy both follow the state.
  assign rk_valid = (state == ST_RUN);
  assign busy     = (state == ST_RUN);

  always_comb begin
    state_n = state;
    key_n   = round_key;
    idx_n   = round_idx;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          key_n   = last_key;
          idx_n   = 4'(NR);
        end
      end
      ST_RUN: begin
        if (rk_ready) begin
          if (round_idx != 4'd0) begin
            key_n = {p0, p1, p2, p3};
            idx_n = round_idx - 4'd1;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      round_key <= '0;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      round_key <= key_n;
      round_idx <= idx_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// tb/tb_aes_inv_key_scheduler.sv - self-checking bench for aes_inv_key_scheduler
module tb_aes_inv_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0;
  logic [127:0] last_key = '0;
  logic         rk_ready = 1'b1;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid, busy, done;

  int total = 0;
  int bad = 0;
  int ready_pct = 100;

  aes_inv_key_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference S-box derived from GF(2^8) inversion plus the affine map.
  logic [7:0] ref_sbox [256];
  logic [7:0] rc [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc[j] = xt(rc[j-1]);
  endtask

  // Model: rebuild the whole 44-word expanded key from its last four words.
  logic [127:0] exp_keys [11];

  task automatic build(input logic [127:0] lk);
    logic [31:0] w [44];
    logic [31:0] t;
    {w[40], w[41], w[42], w[43]} = lk;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]}
            ^ {rc[i/4], 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Transaction-level expectation: which key is on offer and whether done fires.
  bit m_busy = 0;
  bit m_done = 0;
  int m_idx  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_idx = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          build(last_key);
          m_busy = 1;
          m_idx  = 10;
        end
      end else if (rk_ready) begin
        if (m_idx == 0) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_idx--;
        end
      end
    end
  end

  // Per-cycle compare, then the randomized ready for the next cycle.
  bit           p_hold = 0;
  logic [127:0] p_key;
  logic [3:0]   p_idx;

  always @(negedge clk) begin
    chk("valid", 128'(rk_valid), 128'(m_busy));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("done", 128'(done), 128'(m_done));
    if (m_busy) begin
      chk("round_idx", 128'(round_idx), 128'(m_idx));
      chk("round_key", round_key, exp_keys[m_idx]);
    end
    if (p_hold && rk_valid && !rst) begin
      chk("hold_key", round_key, p_key);
      chk("hold_idx", 128'(round_idx), 128'(p_idx));
    end
    rk_ready = ($urandom_range(0, 99) < ready_pct);
    p_hold = rk_valid && !rk_ready;
    p_key  = round_key;
    p_idx  = round_idx;
  end

  task automatic start_sched(input logic [127:0] k);
    start = 1'b1;
    last_key = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idx(input int want);
    int n = 0;
    while (!(rk_valid && round_idx == 4'(want)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("wait_idx_timeout", 128'(n), 128'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("wait_done_timeout", 128'(n), 128'(0));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] FIPS_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    logic [127:0] snap;
    rst = 1'b1;
    init_tables();
    #1;
    chk("rst_key", round_key, 128'h0);
    chk("rst_idx", 128'(round_idx), 128'h0);
    chk("rst_valid", 128'(rk_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Pin the model against the published vector.
    build(FIPS_K10);
    chk("model_k10", exp_keys[10], FIPS_K10);
    chk("model_k9", exp_keys[9], 128'h549932d1f08557681093ed9cbe2c974e);
    chk("model_k1", exp_keys[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("model_k0", exp_keys[0], 128'h000102030405060708090a0b0c0d0e0f);

    // FIPS run with rk_ready held high: 11 valid cycles then one done pulse.
    ready_pct = 100;
    @(negedge clk);
    start_sched(FIPS_K10);
    for (int k = 0; k < 11; k++) begin
      chk("fips_valid", 128'(rk_valid), 128'h1);
      chk("fips_idx", 128'(round_idx), 128'(10 - k));
      if (k == 0) chk("fips_idx10", round_key, FIPS_K10);
      if (k == 1) chk("fips_idx9", round_key, 128'h549932d1f08557681093ed9cbe2c974e);
      if (k == 9) chk("fips_idx1", round_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      if (k == 10) chk("fips_idx0", round_key, 128'h000102030405060708090a0b0c0d0e0f);
      @(negedge clk);
    end
    chk("fips_done_pulse", 128'(done), 128'h1);
    chk("fips_done_valid", 128'(rk_valid), 128'h0);
    @(negedge clk);
    chk("fips_done_low", 128'(done), 128'h0);

    // Random keys under ~50% backpressure.
    ready_pct = 50;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      start_sched(rnd128());
      wait_done();
      @(negedge clk);
    end

    // Start at idx 5 with another key must be ignored.
    start_sched(rnd128());
    wait_idx(5);
    start = 1'b1;
    last_key = rnd128();
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Asynchronous reset at idx 6, then a fresh full schedule.
    start_sched(rnd128());
    wait_idx(6);
    #2 rst = 1'b1;
    #1;
    chk("midrst_key", round_key, 128'h0);
    chk("midrst_idx", 128'(round_idx), 128'h0);
    chk("midrst_valid", 128'(rk_valid), 128'h0);
    chk("midrst_busy", 128'(busy), 128'h0);
    chk("midrst_done", 128'(done), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_sched(rnd128());
    wait_done();

    // Back-to-back: start in the done cycle.
    ready_pct = 100;
    @(negedge clk);
    start_sched(rnd128());
    wait_done();
    start = 1'b1;
    last_key = rnd128();
    @(negedge clk);
    start = 1'b0;
    chk("b2b_valid", 128'(rk_valid), 128'h1);
    chk("b2b_idx", 128'(round_idx), 128'd10);
    wait_done();
    @(negedge clk);

    // Idle with last_key toggling: nothing may move.
    snap = round_key;
    for (int c = 0; c < 20; c++) begin
      last_key = rnd128();
      @(negedge clk);
      chk("idle_key", round_key, snap);
      chk("idle_idx", 128'(round_idx), 128'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
